// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between the issuing controller, alu_pipe and
// the result consumer.
interface alu_pipe_if #(
  parameter int N = 4
);
  // Handshake: a transfer happens on a rising edge where valid && ready.
  // A producer holds its payload stable while valid && !ready. in_ready is the
  // only combinational return path; every other output is registered.
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   operand1;
  logic [N-1:0]   operand2;
  logic [3:0]     select;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] result;
  logic [3:0]     flags;

  modport master (
    output in_valid, operand1, operand2, select, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, operand1, operand2, select, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked N-bit ALU with a registered 2N-bit result, status flags
// {err, dz, carry, zero} and a multi-cycle restoring divider.
module alu_pipe #(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       reset,
  alu_pipe_if.slave  io_bus,
  output logic [1:0] o_state
);
  localparam int CW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd10;
  localparam logic [3:0] OP_EQ  = 4'd11;
  localparam logic [3:0] OP_LTU = 4'd12;

  logic [1:0]     r_state;
  logic [N-1:0]   r_rem;
  logic [N-1:0]   r_quo;
  logic [N-1:0]   r_div;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_result;
  logic [3:0]     r_flags;
  logic           r_out_valid;

  logic           w_out_free;
  logic           w_in_ready;
  logic           w_accept;
  logic           w_div_start;
  logic           w_load_alu;
  logic           w_load_div;

  logic [2*N-1:0] w_a2;
  logic [2*N-1:0] w_b2;
  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_rol;
  int             w_rot;
  logic [2*N-1:0] w_res;
  logic           w_carry;
  logic           w_dz;
  logic           w_err;

  logic [N:0]     w_shift;
  logic [N:0]     w_trial;
  logic           w_fits;
  logic [N-1:0]   w_rem_next;
  logic [N-1:0]   w_quo_next;
  logic [2*N-1:0] w_div_res;

  assign w_out_free  = !r_out_valid || io_bus.out_ready;
  assign w_in_ready  = (r_state == S_IDLE) && w_out_free;
  assign w_accept    = io_bus.in_valid && w_in_ready;
  assign w_div_start = w_accept && (io_bus.select == OP_DIV) && (io_bus.operand2 != '0);
  assign w_load_alu  = w_accept && !w_div_start;
  assign w_load_div  = (r_state == S_DONE) && w_out_free;

  // Single-cycle datapath; a divide by zero also resolves here.
  always_comb begin
    w_a2    = {{N{1'b0}}, io_bus.operand1};
    w_b2    = {{N{1'b0}}, io_bus.operand2};
    w_dbl   = {io_bus.operand1, io_bus.operand1};
    w_rot   = int'(io_bus.operand2) % N;
    w_rol   = w_dbl << w_rot;
    w_res   = '0;
    w_carry = 1'b0;
    w_dz    = 1'b0;
    w_err   = 1'b0;
    case (io_bus.select)
      OP_ADD: begin
        w_res   = w_a2 + w_b2;
        w_carry = w_res[N];
      end
      OP_SUB: begin
        w_res   = w_a2 - w_b2;
        w_carry = io_bus.operand1 < io_bus.operand2;
      end
      OP_MUL: w_res = w_a2 * w_b2;
      OP_DIV: begin
        if (io_bus.operand2 == '0) begin
          w_res = {io_bus.operand1, {N{1'b1}}};
          w_dz  = 1'b1;
        end
      end
      OP_AND: w_res = w_a2 & w_b2;
      OP_OR:  w_res = w_a2 | w_b2;
      OP_XOR: w_res = w_a2 ^ w_b2;
      OP_NOT: w_res = {{N{1'b0}}, ~io_bus.operand1};
      OP_SHL: w_res = (int'(io_bus.operand2) >= 2 * N) ? '0 : (w_a2 << io_bus.operand2);
      OP_SHR: w_res = (int'(io_bus.operand2) >= N) ? '0 : (w_a2 >> io_bus.operand2);
      OP_ROL: w_res = {{N{1'b0}}, w_rol[2*N-1:N]};
      OP_EQ:  w_res = {{(2*N-1){1'b0}}, io_bus.operand1 == io_bus.operand2};
      OP_LTU: w_res = {{(2*N-1){1'b0}}, io_bus.operand1 < io_bus.operand2};
      default: w_err = 1'b1;
    endcase
  end

  // One restoring step: the shifted partial remainder stays below 2*divisor,
  // so the sign bit of the (N+1)-bit trial difference is the borrow.
  always_comb begin
    w_shift    = {r_rem, r_quo[N-1]};
    w_trial    = w_shift - {1'b0, r_div};
    w_fits     = !w_trial[N];
    w_rem_next = w_fits ? w_trial[N-1:0] : w_shift[N-1:0];
    w_quo_next = {r_quo[N-2:0], w_fits};
    w_div_res  = {r_rem, r_quo};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_div_start) begin
            r_state <= S_DIV;
            r_rem   <= '0;
            r_quo   <= io_bus.operand1;
            r_div   <= io_bus.operand2;
            r_cnt   <= CW'(N - 1);
          end
        end
        S_DIV: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (r_cnt == '0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          if (w_out_free) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Consume and reload on the same edge keeps out_valid high.
      if (w_load_alu) begin
        r_result    <= w_res;
        r_flags     <= {w_err, w_dz, w_carry, w_res == '0};
        r_out_valid <= 1'b1;
      end else if (w_load_div) begin
        r_result    <= w_div_res;
        r_flags     <= {3'b000, w_div_res == '0};
        r_out_valid <= 1'b1;
      end else if (io_bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.result    = r_result;
  assign io_bus.flags     = r_flags;
  assign o_state          = r_state;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed cases on an N=4 instance, randomised traffic on
// an N=8 instance, both checked by a queue-based scoreboard against a model.
module tb_alu_pipe;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] state4;
  logic [1:0] state8;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp4_q[$];
  logic [35:0] exp8_q[$];
  bit rand_phase = 1'b0;

  always #5 clk = ~clk;

  alu_pipe_if #(.N(4)) bus4 ();
  alu_pipe_if #(.N(8)) bus8 ();

  alu_pipe #(.N(4)) dut4 (.clk(clk), .reset(reset), .io_bus(bus4.slave), .o_state(state4));
  alu_pipe #(.N(8)) dut8 (.clk(clk), .reset(reset), .io_bus(bus8.slave), .o_state(state8));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: {err, dz, carry, zero, result[31:0]} from plain integer arithmetic.
  function automatic logic [35:0] model(input int n, input int op, input longint a, input longint b);
    longint mn, m2, res;
    int r;
    logic c, dz, err;
    mn = (longint'(1) << n) - 1;
    m2 = (longint'(1) << (2 * n)) - 1;
    res = 0; c = 1'b0; dz = 1'b0; err = 1'b0;
    case (op)
      0: begin res = a + b; c = (a + b) > mn; end
      1: begin res = (a - b) & m2; c = a < b; end
      2: res = a * b;
      3: if (b == 0) begin res = (a << n) | mn; dz = 1'b1; end
         else res = ((a % b) << n) | (a / b);
      4: res = a & b;
      5: res = a | b;
      6: res = a ^ b;
      7: res = (~a) & mn;
      8: res = (b >= 2 * n) ? 0 : ((a << b) & m2);
      9: res = (b >= n) ? 0 : (a >> b);
      10: begin r = int'(b % n); res = ((a << r) | (a >> (n - r))) & mn; end
      11: res = (a == b) ? 1 : 0;
      12: res = (a < b) ? 1 : 0;
      default: err = 1'b1;
    endcase
    return {err, dz, c, res == 0, res[31:0]};
  endfunction

  // Callers invoke send one time unit after a rising edge.
  task automatic send(input int inst, input int op, input int a, input int b);
    int waited = 0;
    bit rdy = 1'b0;
    if (inst == 4) begin
      bus4.in_valid = 1'b1; bus4.select = 4'(op); bus4.operand1 = 4'(a); bus4.operand2 = 4'(b);
    end else begin
      bus8.in_valid = 1'b1; bus8.select = 4'(op); bus8.operand1 = 8'(a); bus8.operand2 = 8'(b);
    end
    forever begin
      @(negedge clk);
      rdy = (inst == 4) ? bus4.in_ready : bus8.in_ready;
      if (rdy) break;
      waited++;
      if (waited > 100) begin
        checks++; errors++;
        $display("FAIL accept_timeout inst%0d op %0d: in_ready stayed 0, expected 1", inst, op);
        break;
      end
    end
    if (rdy) begin
      @(posedge clk);
      if (inst == 4) exp4_q.push_back(model(4, op, a, b));
      else           exp8_q.push_back(model(8, op, a, b));
    end
    #1;
    if (inst == 4) bus4.in_valid = 1'b0;
    else           bus8.in_valid = 1'b0;
  endtask

  task automatic drain(input int inst, input int bound);
    int w = 0;
    while (((inst == 4) ? exp4_q.size() : exp8_q.size()) != 0 && w < bound) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [35:0] e;
    if (!reset && bus4.out_valid && bus4.out_ready) begin
      if (exp4_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out4_unexpected: got result %0h, expected no output", bus4.result);
      end else begin
        e = exp4_q.pop_front();
        check("res4", 32'(bus4.result), e[31:0]);
        check("flags4", 32'(bus4.flags), 32'(e[35:32]));
      end
    end
  end

  always @(negedge clk) begin
    logic [35:0] e;
    if (!reset && bus8.out_valid && bus8.out_ready) begin
      if (exp8_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out8_unexpected: got result %0h, expected no output", bus8.result);
      end else begin
        e = exp8_q.pop_front();
        check("res8", 32'(bus8.result), e[31:0]);
        check("flags8", 32'(bus8.flags), 32'(e[35:32]));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_phase) begin
      #1;
      bus8.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    checks++; errors++;
    $display("FAIL watchdog: simulation still running, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int cnt;
    int op, a, b;
    reset = 1'b1;
    bus4.in_valid = 1'b0; bus4.operand1 = '0; bus4.operand2 = '0; bus4.select = '0; bus4.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.operand1 = '0; bus8.operand2 = '0; bus8.select = '0; bus8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus4.out_valid), 0);
    check("rst_result", 32'(bus4.result), 0);
    check("rst_flags", 32'(bus4.flags), 0);
    check("rst_state", 32'(state4), 0);
    check("rst_in_ready", 32'(bus4.in_ready), 1);
    check("rst_out_valid8", 32'(bus8.out_valid), 0);
    @(posedge clk); #1;

    send(4, 0, 15, 1);
    check("add_latency", 32'(bus4.out_valid), 1);
    check("add_result", 32'(bus4.result), 32'h10);
    check("add_flags", 32'(bus4.flags), 32'b0010);

    send(4, 1, 3, 5);
    send(4, 2, 15, 15);
    send(4, 10, 9, 1);
    send(4, 14, 0, 0);
    check("stream_err_result", 32'(bus4.result), 0);
    check("stream_err_flags", 32'(bus4.flags), 32'b1001);
    drain(4, 20);

    send(4, 3, 13, 4);
    cnt = 0;
    forever begin
      @(negedge clk);
      if (bus4.in_ready || cnt > 50) break;
      cnt++;
    end
    check("div_busy_cycles", cnt, 5);
    check("div_out_valid", 32'(bus4.out_valid), 1);
    check("div_result", 32'(bus4.result), 32'h13);
    @(posedge clk); #1;

    send(4, 3, 9, 0);
    check("divz_latency", 32'(bus4.out_valid), 1);
    check("divz_result", 32'(bus4.result), 32'h9F);
    check("divz_flags", 32'(bus4.flags), 32'b0100);
    drain(4, 20);

    bus4.out_ready = 1'b0;
    send(4, 4, 12, 10);
    bus4.in_valid = 1'b1; bus4.select = 4'd5; bus4.operand1 = 4'd3; bus4.operand2 = 4'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus4.out_valid), 1);
      check("bp_in_ready", 32'(bus4.in_ready), 0);
      check("bp_result", 32'(bus4.result), 32'h08);
      check("bp_flags", 32'(bus4.flags), 0);
    end
    @(posedge clk); #1;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_return", 32'(bus4.in_ready), 1);
    @(posedge clk);
    exp4_q.push_back(model(4, 5, 3, 4));
    #1;
    bus4.in_valid = 1'b0;
    check("bp_valid_kept", 32'(bus4.out_valid), 1);
    check("bp_new_result", 32'(bus4.result), 32'h07);
    drain(4, 20);

    send(4, 3, 15, 2);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp4_q.delete();
    #1;
    check("abort_out_valid", 32'(bus4.out_valid), 0);
    check("abort_state", 32'(state4), 0);
    check("abort_result", 32'(bus4.result), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_result", 32'(bus4.out_valid), 0);
    check("abort_idle", 32'(state4), 0);
    @(posedge clk); #1;
    send(4, 0, 1, 1);
    check("post_abort_add", 32'(bus4.result), 32'h02);
    drain(4, 20);

    rand_phase = 1'b1;
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 3 : int'($urandom_range(0, 15));
      a  = int'($urandom_range(0, 255));
      b  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      send(8, op, a, b);
      cnt = int'($urandom_range(0, 2));
      if (cnt > 0) begin
        repeat (cnt) @(posedge clk);
        #1;
      end
    end
    rand_phase = 1'b0;
    @(posedge clk); #1;
    bus8.out_ready = 1'b1;
    drain(8, 300);

    check("q4_empty", 32'(exp4_q.size()), 0);
    check("q8_empty", 32'(exp8_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised N-bit ALU with valid/ready handshakes on input and output, a registered 2N-bit result with status flags, and a multi-cycle restoring divider. It is the handshaked successor to the free-running registered ALU top. It sits between an operand-issuing controller and a result consumer that may apply backpressure.

## Interface
- N, default 4, operand width (N >= 2); result width 2N
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operands/op presented
- in_ready  output  1  block can accept this cycle (combinational)
- operand1  input  N  operand a, unsigned
- operand2  input  N  operand b, unsigned
- select  input  4  opcode
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- result  output  2N  registered result
- flags  output  4  {err, dz, carry, zero}, registered alongside result

## Operation
- Opcodes; operands are zero-extended to 2N bits unless stated:
  - 0 ADD: a+b.
  - 1 SUB: (a-b) mod 2^(2N).
  - 2 MUL: a*b, unsigned.
  - 3 DIV: result = {remainder, quotient}, unsigned.
  - 4 AND, 5 OR, 6 XOR.
  - 7 NOT: ~a in the low N bits, upper bits 0.
  - 8 SHL: a<<b; shift amounts >= 2N give 0.
  - 9 SHR: logical a>>b; amounts >= N give 0.
  - 10 ROL: rotate a left by b mod N within N bits.
  - 11 EQ: 1 if a==b, else 0.
  - 12 LTU: 1 if a<b, else 0.
  - 13-15 illegal: result 0, err=1.
- Flags:
  - zero = (result==0).
  - carry = ADD carry out of bit N-1, or SUB borrow (a<b); 0 for every other op.
  - dz = DIV with b==0.
  - err = illegal opcode.
- Divide by zero: quotient all ones, remainder = a, dz=1. Completes in single-cycle latency; the divider is not entered.
- FSM states IDLE, DIV, DONE:
  - IDLE -> DIV on acceptance of DIV with b!=0. Load remainder=0, quotient=a, count=N-1.
  - DIV: one restoring step per cycle: shift {rem,quo} left, trial-subtract b, set quotient LSB.
  - DIV -> DONE after the step with count==0.
  - DONE -> IDLE when the output register is free (!out_valid or out_ready). The divide result and flags load on that edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Acceptance: in_valid && in_ready at a rising edge. Non-DIV ops (and DIV by zero) load result/flags on that same edge.
- out_valid rises on the load edge. It falls at an edge where out_ready=1 and no new load occurs.
- Backpressure: while out_valid && !out_ready, result and flags hold stable. in_ready is 0, so no operand is lost.
- Operands are sampled only at acceptance. Input changes during DIV have no effect.

## Timing
- Reset values: out_valid=0, result=0, flags=0, state=IDLE, divider registers 0. in_ready=1 while reset is low and no output is pending.
- Non-DIV latency: accepted at edge k, out_valid=1 after edge k. Throughput is 1 op/cycle with out_ready held 1.
- DIV latency (b!=0): accepted at edge k; N step edges k+1..k+N; DONE->load at edge k+N+1 if the output is free, later otherwise. in_ready=0 from edge k until the load edge.
- Simultaneous out_ready handshake and new acceptance: the old result is consumed and the new one loaded on the same edge, with out_valid staying 1.
- Reset asserted mid-division or with a pending output: aborts immediately, returns to reset values, no result emitted.
- Output fully registered. in_ready is the only combinational output; it depends on state, out_valid and out_ready.

## Test plan
- Reset then ADD with N=4, a=15, b=1, out_ready=1 -> result=8'h10, flags=4'b0010, out_valid one cycle after acceptance.
- Back-to-back stream SUB 3-5, MUL 15*15, ROL 4'b1001 by 1, op 14, out_ready=1 -> results 8'hFE (carry=1), 8'hE1, 8'h03, 8'h00 (err=1) on consecutive cycles.
- DIV 13/4 -> in_ready low for N+1 cycles, result={4'd1,4'd3}. DIV 9/0 -> result=8'h9F, dz=1, 1-cycle latency.
- Backpressure: out_ready=0 for 5 cycles after an AND -> result/flags stable, in_ready=0, next op accepted the same edge out_ready returns to 1.
- Reset asserted 2 cycles into DIV 15/2 -> out_valid stays 0, state IDLE, the next ADD 1+1 returns 8'h02.
- Randomised mixed ops at N=8 with random out_ready -> every accepted op yields exactly one in-order result matching the golden model.
